// File: rtl/nu_rangefinder_axi_regs_pkg.sv
// Shared constants and helpers for the rangefinder AXI4-Lite register block.
// Contents:
//   RESP_OKAY / RESP_EXOKAY  AXI response encodings
//   REG_IDX_W / NUM_REGS     register index width and register count
//   REG*_OFS                 byte offsets of the four software registers
//   idx_onehot()             register index to one-hot select
package nu_rangefinder_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned NUM_REGS  = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam logic [3:0] REG_CTRL_OFS = 4'h0;
    localparam logic [3:0] REG1_OFS     = 4'h4;
    localparam logic [3:0] REG2_OFS     = 4'h8;
    localparam logic [3:0] REG3_OFS     = 4'hC;

    function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
        logic [NUM_REGS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/nu_rangefinder_axi_regs_if.sv
// AXI4-Lite bus bundle for the rangefinder register block.
// Modports:
//   master  drives AW/W/AR channels and BREADY/RREADY
//   slave   drives AWREADY/WREADY/ARREADY and the B and R channels
interface nu_rangefinder_axi_regs_if #(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/nu_axil_byte_reg.sv
// One software register with per-byte write enables and a reset value.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset, loads RESET_VAL
//   we     write enable for this register
//   strb   byte lane enables, bit b covers wdata[8b+7:8b]
//   wdata  write data
//   q      current register contents
module nu_axil_byte_reg #(
    parameter int unsigned     DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] strb,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q
);

    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (strb[b]) begin
                    data_d[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/nu_rangefinder_axi_regs.sv
// AXI4-Lite slave holding the four software registers of the rangefinder VGA IP.
// Ports:
//   ACLK, ARESET       clock and synchronous active-high reset
//   s_axi              AXI4-Lite slave bundle (AW, W, B, AR, R channels)
//   reg0_out..reg3_out current register contents to the datapath
//   reg_wr_pulse       bit i high for one cycle after register i commits a write
// Address bits [3:2] pick the register; [1:0] and AxPROT are ignored. Responses
// are always OKAY. One write and one read may be outstanding at a time.
module nu_rangefinder_axi_regs
    import nu_rangefinder_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] C_RESET_VAL        = 32'h0000_0000
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    nu_rangefinder_axi_regs_if.slave      s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_out,
    output logic [NUM_REGS-1:0]           reg_wr_pulse
);

    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;

    // Write channel state
    logic                          aw_held_q, aw_held_d;
    reg_idx_t                      aw_idx_q, aw_idx_d;
    logic                          w_held_q, w_held_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]             wstrb_q, wstrb_d;
    logic                          bvalid_q, bvalid_d;
    logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;

    // Read channel state
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic awready, wready, arready;
    logic aw_hs, w_hs, ar_hs, commit;

    reg_idx_t                      wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]             wr_strb;
    logic [NUM_REGS-1:0]           reg_we;
    logic [C_S_AXI_DATA_WIDTH-1:0] reg_q [NUM_REGS];

    logic unused_bits;

    assign awaddr = s_axi.S_AXI_AWADDR;
    assign araddr = s_axi.S_AXI_ARADDR;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr[1:0], araddr[1:0]};

    // Ready terms depend on ARESET directly so nothing is accepted during reset.
    assign awready = !ARESET && !aw_held_q && !bvalid_q;
    assign wready  = !ARESET && !w_held_q && !bvalid_q;
    assign arready = !ARESET && !rvalid_q;

    assign aw_hs = s_axi.S_AXI_AWVALID && awready;
    assign w_hs  = s_axi.S_AXI_WVALID && wready;
    assign ar_hs = s_axi.S_AXI_ARVALID && arready;

    // Commit as soon as both address and data are available, whether latched
    // earlier or handshaking on this edge.
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_idx  = aw_hs ? reg_idx_t'(awaddr[3:2]) : aw_idx_q;
    assign wr_data = w_hs ? s_axi.S_AXI_WDATA : wdata_q;
    assign wr_strb = w_hs ? s_axi.S_AXI_WSTRB : wstrb_q;
    assign reg_we  = commit ? idx_onehot(wr_idx) : '0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        nu_axil_byte_reg #(
            .DATA_W    (C_S_AXI_DATA_WIDTH),
            .RESET_VAL (C_RESET_VAL)
        ) u_reg (
            .clk   (ACLK),
            .rst   (ARESET),
            .we    (reg_we[i]),
            .strb  (wr_strb),
            .wdata (wr_data),
            .q     (reg_q[i])
        );
    end

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        wr_pulse_d = reg_we;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = reg_idx_t'(awaddr[3:2]);
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.S_AXI_WDATA;
            wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        // Commit only happens while BVALID is low, so it never races a B handshake.
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // Register array is sampled before this edge's write lands: same-edge
        // read of the written register returns the old value.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = reg_q[reg_idx_t'(araddr[3:2])];
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;
    assign s_axi.S_AXI_RVALID  = rvalid_q;

    assign reg0_out     = reg_q[0];
    assign reg1_out     = reg_q[1];
    assign reg2_out     = reg_q[2];
    assign reg3_out     = reg_q[3];
    assign reg_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_nu_rangefinder_axi_regs.sv
// Self-checking bench for nu_rangefinder_axi_regs. Read data is predicted from a
// register model at the AR handshake and queued; a negedge monitor pops and
// compares on every R handshake and checks every B response.
module tb_nu_rangefinder_axi_regs;
    import nu_rangefinder_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;
    logic [3:0]  reg_wr_pulse;

    nu_rangefinder_axi_regs_if #(.C_S_AXI_ADDR_WIDTH(4), .C_S_AXI_DATA_WIDTH(32)) axi ();

    nu_rangefinder_axi_regs dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .s_axi        (axi),
        .reg0_out     (reg0_out),
        .reg1_out     (reg1_out),
        .reg2_out     (reg2_out),
        .reg3_out     (reg3_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_errors = 0;
    int          b_count  = 0;
    int          r_count  = 0;
    logic [31:0] exp_regs [4];
    logic [31:0] rd_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_out(input int i);
        case (i)
            0:       return reg0_out;
            1:       return reg1_out;
            2:       return reg2_out;
            default: return reg3_out;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Response monitor / scoreboard consumer
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
                check_val("bresp", 32'(axi.S_AXI_BRESP), 32'(RESP_OKAY));
                b_count++;
            end
            if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
                if (rd_q.size() == 0) begin
                    check_val("r_unexpected", 32'(rd_q.size()), 32'd1);
                end else begin
                    logic [31:0] e;
                    e = rd_q.pop_front();
                    check_val("rdata", axi.S_AXI_RDATA, e);
                    check_val("rresp", 32'(axi.S_AXI_RRESP), 32'(RESP_OKAY));
                end
                r_count++;
            end
        end
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_hold);
        bit          aw_done, w_done, aw_now, w_now;
        int          c, target, idx;
        logic [3:0]  exp_pulse;
        aw_done = 0;
        w_done  = 0;
        c       = 0;
        idx     = int'(addr[3:2]);
        target  = b_count + 1;
        if (b_hold > 0) axi.S_AXI_BREADY = 1'b0;
        while (!(aw_done && w_done) && c < 30) begin
            if (c == aw_dly) begin
                axi.S_AXI_AWADDR  = addr;
                axi.S_AXI_AWVALID = 1'b1;
            end
            if (c == w_dly) begin
                axi.S_AXI_WDATA  = data;
                axi.S_AXI_WSTRB  = strb;
                axi.S_AXI_WVALID = 1'b1;
            end
            @(negedge ACLK);
            check_val("bvalid_early", 32'(axi.S_AXI_BVALID), 32'd0);
            aw_now = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            w_now  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
            @(posedge ACLK);
            #1;
            if (aw_now) begin
                axi.S_AXI_AWVALID = 1'b0;
                aw_done = 1;
            end
            if (w_now) begin
                axi.S_AXI_WVALID = 1'b0;
                w_done = 1;
            end
            c++;
        end
        check_val("wr_hs", 32'(aw_done && w_done), 32'd1);
        if (!(aw_done && w_done)) begin
            axi.S_AXI_AWVALID = 1'b0;
            axi.S_AXI_WVALID  = 1'b0;
            axi.S_AXI_BREADY  = 1'b1;
            return;
        end
        exp_regs[idx] = merge(exp_regs[idx], data, strb);
        exp_pulse = 4'b0001 << idx;
        @(negedge ACLK);
        check_val("bvalid_lat", 32'(axi.S_AXI_BVALID), 32'd1);
        check_val("wr_pulse", 32'(reg_wr_pulse), 32'(exp_pulse));
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        check_val("wr_pulse_clr", 32'(reg_wr_pulse), 32'd0);
        for (int i = 0; i < b_hold; i++) begin
            check_val("bvalid_hold", 32'(axi.S_AXI_BVALID), 32'd1);
            check_val("awready_stall", 32'(axi.S_AXI_AWREADY), 32'd0);
            check_val("wready_stall", 32'(axi.S_AXI_WREADY), 32'd0);
            @(posedge ACLK);
            #1;
            if (i == b_hold - 1) axi.S_AXI_BREADY = 1'b1;
            @(negedge ACLK);
        end
        c = 0;
        while (b_count < target && c < 20) begin
            @(negedge ACLK);
            c++;
        end
        @(negedge ACLK);
        check_val("b_once", 32'(b_count), 32'(target));
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_hold);
        bit          done, ar_now;
        int          c, target;
        logic [31:0] e;
        done   = 0;
        c      = 0;
        e      = '0;
        target = r_count + 1;
        if (r_hold > 0) axi.S_AXI_RREADY = 1'b0;
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        while (!done && c < 30) begin
            @(negedge ACLK);
            ar_now = axi.S_AXI_ARREADY;
            if (ar_now) begin
                e = exp_regs[int'(addr[3:2])];
                rd_q.push_back(e);
            end
            @(posedge ACLK);
            #1;
            if (ar_now) begin
                axi.S_AXI_ARVALID = 1'b0;
                done = 1;
            end
            c++;
        end
        check_val("ar_hs", 32'(done), 32'd1);
        if (!done) begin
            axi.S_AXI_ARVALID = 1'b0;
            axi.S_AXI_RREADY  = 1'b1;
            return;
        end
        @(negedge ACLK);
        check_val("rvalid_lat", 32'(axi.S_AXI_RVALID), 32'd1);
        for (int i = 0; i < r_hold; i++) begin
            check_val("rvalid_hold", 32'(axi.S_AXI_RVALID), 32'd1);
            check_val("rdata_hold", axi.S_AXI_RDATA, e);
            check_val("arready_stall", 32'(axi.S_AXI_ARREADY), 32'd0);
            @(posedge ACLK);
            #1;
            if (i == r_hold - 1) axi.S_AXI_RREADY = 1'b1;
            @(negedge ACLK);
        end
        c = 0;
        while (r_count < target && c < 20) begin
            @(negedge ACLK);
            c++;
        end
        check_val("r_done", 32'(r_count >= target), 32'd1);
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) check_val(tag, reg_out(i), exp_regs[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [3:0]  seq_addr [3];
    logic [31:0] seq_data [3];

    initial begin
        for (int i = 0; i < 4; i++) exp_regs[i] = 32'h0;
        axi.S_AXI_AWADDR  = '0;
        axi.S_AXI_AWPROT  = 3'b000;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA   = '0;
        axi.S_AXI_WSTRB   = '0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b1;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARPROT  = 3'b000;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b1;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_val("rst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
        check_val("rst_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
        check_val("rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
        check_val("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
        check_val("rst_pulse", 32'(reg_wr_pulse), 32'd0);
        check_regs("rst_reg");
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        check_val("idle_awready", 32'(axi.S_AXI_AWREADY), 32'd1);
        check_val("idle_wready", 32'(axi.S_AXI_WREADY), 32'd1);
        check_val("idle_arready", 32'(axi.S_AXI_ARREADY), 32'd1);
        @(posedge ACLK);
        #1;

        // Basic write/read of register 0
        axi_write(REG_CTRL_OFS, 32'h0101FFFF, 4'hF, 0, 0, 0);
        axi_read(REG_CTRL_OFS, 0);
        check_val("reg0_basic", reg0_out, 32'h0101FFFF);

        // Sequential write/read of the other registers
        seq_addr[0] = REG1_OFS; seq_data[0] = 32'habcd0001;
        seq_addr[1] = REG2_OFS; seq_data[1] = 32'hdead0011;
        seq_addr[2] = REG3_OFS; seq_data[2] = 32'hbeef0011;
        for (int i = 0; i < 3; i++) begin
            axi_write(seq_addr[i], seq_data[i], 4'hF, 0, 0, 0);
            axi_read(seq_addr[i], 0);
        end
        check_regs("seq_reg");
        axi_read(4'h6, 0);  // low address bits ignored, selects register 1

        // Channel ordering: W first, AW first, then together
        axi_write(REG3_OFS, 32'h11112222, 4'hF, 3, 0, 0);
        axi_read(REG3_OFS, 0);
        axi_write(REG3_OFS, 32'h33334444, 4'hF, 0, 3, 0);
        axi_read(REG3_OFS, 0);
        axi_write(REG3_OFS, 32'h55556666, 4'hF, 0, 0, 0);
        axi_read(REG3_OFS, 0);

        // Partial strobe merge with B back-pressure
        axi_write(REG1_OFS, 32'h12345678, 4'b0101, 0, 0, 3);
        check_val("reg1_merge", reg1_out, 32'hab340078);
        axi_read(REG1_OFS, 0);

        // Zero strobe: completes, no change
        axi_write(REG2_OFS, 32'hffffffff, 4'h0, 0, 0, 0);
        check_val("reg2_nostrb", reg2_out, 32'hdead0011);

        // R back-pressure, then same-edge write and read of register 2
        axi_read(REG2_OFS, 4);
        fork
            axi_write(REG2_OFS, 32'h0, 4'hF, 0, 0, 0);
            axi_read(REG2_OFS, 0);
        join
        axi_read(REG2_OFS, 0);
        check_regs("post_same_edge");

        // Reset with BVALID and RVALID both pending
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;
        axi.S_AXI_AWADDR  = REG_CTRL_OFS;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = 32'h5a5a5a5a;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_WVALID  = 1'b1;
        axi.S_AXI_ARADDR  = REG1_OFS;
        axi.S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK);
        #1;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_ARVALID = 1'b0;
        exp_regs[0] = 32'h5a5a5a5a;
        @(negedge ACLK);
        check_val("pre_rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
        check_val("pre_rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd1);
        check_val("pre_rst_reg0", reg0_out, exp_regs[0]);
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(negedge ACLK);
        check_val("mid_rst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
        check_val("mid_rst_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        for (int i = 0; i < 4; i++) exp_regs[i] = 32'h0;
        @(negedge ACLK);
        check_val("post_rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
        check_val("post_rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
        check_val("post_rst_pulse", 32'(reg_wr_pulse), 32'd0);
        check_val("post_rst_awready", 32'(axi.S_AXI_AWREADY), 32'd1);
        check_regs("post_rst_reg");
        @(posedge ACLK);
        #1;
        axi.S_AXI_BREADY = 1'b1;
        axi.S_AXI_RREADY = 1'b1;

        axi_write(REG2_OFS, 32'hcafe0042, 4'hF, 0, 0, 0);
        axi_read(REG2_OFS, 0);
        axi_read(REG_CTRL_OFS, 0);
        check_regs("final_reg");
        check_val("rd_q_empty", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
